// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parametrised single-clock FIFO with level, thresholds, flush and sticky error flags
//
// Purpose:
//   Synchronous FIFO between the bus-side command writer and the pixel pipeline reader.
//   Depth is 1 << ADDR_WIDTH words; level is a separate counter (0..DEPTH) so pointers
//   can wrap naturally. Status flags are decoded from the registered level.
//
// Optional feature macro: PARAM_FIFO_FWFT_EN
//   defined   - first-word-fall-through: dataout shows the head word combinationally (0 when empty)
//   undefined - registered read: dataout updates one cycle after an accepted read and holds otherwise
//
// Ports:
//   clockin        in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   datain         in   write data (DATA_WIDTH)
//   datain_enable  in   write request
//   dataout        out  read data (DATA_WIDTH)
//   dataout_enable in   read request
//   flush          in   synchronous clear of contents (priority over read/write)
//   clear_flags    in   synchronous clear of overflow/underflow
//   full           out  level == DEPTH
//   empty          out  level == 0
//   almost_full    out  level >= ALMOST_FULL_LEVEL
//   almost_empty   out  level <= ALMOST_EMPTY_LEVEL
//   level          out  current word count (ADDR_WIDTH+1)
//   overflow       out  sticky: a write was rejected
//   underflow      out  sticky: a read was rejected

module param_fifo #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDR_WIDTH         = 4,
  parameter int ALMOST_FULL_LEVEL  = (1 << ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                  clockin,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  datain_enable,
  output logic [DATA_WIDTH-1:0] dataout,
  input  logic                  dataout_enable,
  input  logic                  flush,
  input  logic                  clear_flags,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;

  // Elaboration-time rejection of parameter sets with no defined behaviour.
  if (ADDR_WIDTH < 1) begin : g_bad_addr_width
    $error("param_fifo: ADDR_WIDTH must be at least 1");
  end
  if (ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_almost_full
    $error("param_fifo: ALMOST_FULL_LEVEL exceeds DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Status decode from the registered level only.
  always_comb begin
    full         = (level == LW'(DEPTH));
    empty        = (level == '0);
    almost_full  = (int'(level) >= ALMOST_FULL_LEVEL);
    almost_empty = (int'(level) <= ALMOST_EMPTY_LEVEL);
  end

  // A read frees a slot in the same cycle, so a full FIFO still takes a write
  // alongside an accepted read; the reverse is not true for an empty FIFO.
  always_comb begin
    rd_ok = dataout_enable && !empty;
    wr_ok = datain_enable && (!full || rd_ok);
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clockin) begin
    if (!flush && wr_ok) begin
      mem[wptr] <= datain;
    end
  end

  always_ff @(posedge clockin or negedge reset_n) begin
    if (!reset_n) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        level <= '0;
      end else begin
        if (wr_ok) wptr <= wptr + ADDR_WIDTH'(1);
        if (rd_ok) rptr <= rptr + ADDR_WIDTH'(1);
        if (wr_ok && !rd_ok) begin
          level <= level + LW'(1);
        end else if (rd_ok && !wr_ok) begin
          level <= level - LW'(1);
        end
      end
      // Clear first so that a coincident new violation wins.
      if (clear_flags) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (!flush && datain_enable && !wr_ok) overflow <= 1'b1;
      if (!flush && dataout_enable && !rd_ok) underflow <= 1'b1;
    end
  end

`ifdef PARAM_FIFO_FWFT_EN
  assign dataout = empty ? '0 : mem[rptr];
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clockin or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= '0;
    end else if (!flush && rd_ok) begin
      dout_q <= mem[rptr];
    end
  end

  assign dataout = dout_q;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - self-checking bench for param_fifo against a queue reference model

module tb_param_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] datain;
  logic          datain_enable;
  logic [DW-1:0] dataout;
  logic          dataout_enable;
  logic          flush;
  logic          clear_flags;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          underflow;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_unf;

  param_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ALMOST_FULL_LEVEL(AF),
    .ALMOST_EMPTY_LEVEL(AE)
  ) dut (
    .clockin(clk),
    .reset_n(reset_n),
    .datain(datain),
    .datain_enable(datain_enable),
    .dataout(dataout),
    .dataout_enable(dataout_enable),
    .flush(flush),
    .clear_flags(clear_flags),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .level(level),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    int lvl;
    logic [DW-1:0] exp_dout;
    lvl = q.size();
`ifdef PARAM_FIFO_FWFT_EN
    exp_dout = (lvl != 0) ? q[0] : '0;
`else
    exp_dout = m_dout;
`endif
    check({tag, ".level"}, 32'(level), 32'(lvl));
    check({tag, ".full"}, 32'(full), 32'(lvl == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(lvl == 0));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(lvl >= AF));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(lvl <= AE));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    check({tag, ".dataout"}, 32'(dataout), 32'(exp_dout));
  endtask

  // Drive one cycle of requests, advance the reference model, then compare after the edge.
  task automatic step(input string tag, input logic we, input logic [DW-1:0] d,
                      input logic re, input logic fl, input logic cf);
    bit rd_acc;
    bit wr_acc;
    datain         = d;
    datain_enable  = we;
    dataout_enable = re;
    flush          = fl;
    clear_flags    = cf;
    @(posedge clk);
    #1;
    if (cf) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (fl) begin
      q.delete();
    end else begin
      rd_acc = re && (q.size() > 0);
      wr_acc = we && ((q.size() < DEPTH) || rd_acc);
      if (rd_acc) m_dout = q.pop_front();
      if (wr_acc) q.push_back(d);
      if (we && !wr_acc) m_ovf = 1'b1;
      if (re && !rd_acc) m_unf = 1'b1;
    end
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    datain         = '0;
    datain_enable  = 1'b0;
    dataout_enable = 1'b0;
    flush          = 1'b0;
    clear_flags    = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    compare_all("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Fill to full, then one rejected write.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, DW'(8'h11 + i), 1'b0, 1'b0, 1'b0);
    check("fill.level16", 32'(level), 32'd16);
    step("overflow", 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    check("overflow.set", 32'(overflow), 32'd1);
    step("clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Drain, then one rejected read.
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifndef PARAM_FIFO_FWFT_EN
    check("drain.last", 32'(dataout), 32'h20);
`endif
    step("underflow", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifndef PARAM_FIFO_FWFT_EN
    check("underflow.hold", 32'(dataout), 32'h20);
`endif
    step("clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Simultaneous read+write when full.
    for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
    step("full_rw", 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    check("full_rw.level", 32'(level), 32'd16);
    for (int i = 0; i < DEPTH; i++) step("full_rw_drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifndef PARAM_FIFO_FWFT_EN
    check("full_rw.aa_last", 32'(dataout), 32'hAA);
`endif

    // Simultaneous read+write when empty.
    step("empty_rw", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    check("empty_rw.level", 32'(level), 32'd1);
    step("empty_rw_read", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifndef PARAM_FIFO_FWFT_EN
    check("empty_rw.data", 32'(dataout), 32'h55);
`endif

    // Flush with contents, clear flags, round trip.
    for (int i = 0; i < 5; i++) step("pre_flush", 1'b1, DW'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    step("flush", 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    step("clear", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step("rt_write", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    step("rt_read", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom % 100) < 55, DW'($urandom), ($urandom % 100) < 50,
           ($urandom % 50) == 0, ($urandom % 30) == 0);
    end

    // Asynchronous reset mid-burst at level 7 with a sticky flag set.
    step("pre_rst_flush", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step("pre_rst_unf", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step("burst", 1'b1, DW'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    step("burst_rd", 1'b1, 8'h67, 1'b1, 1'b0, 1'b0);
    check("burst.level7", 32'(level), 32'd7);
    idle_inputs();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("post_rst_write", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
`ifdef PARAM_FIFO_FWFT_EN
    check("fwft.3c", 32'(dataout), 32'h3C);
`endif
    step("post_rst_read", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
